pe_sequencer: RTL and testbench

PE_SEQUENCER -- requirements
Module: pe_sequencer

---
 rtl/pe_pkg.sv | 31 +++
 rtl/pe_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_pe_sequencer.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pe_pkg.sv
// Shared types for the PE sequencer: PE configuration word, PE op codes and FSM states.
package pe_pkg;

    typedef struct packed {
        logic [3:0] op;
        logic [1:0] vsew;
        logic [1:0] widening;
        logic [1:0] mul_us;
        logic [1:0] saturate_mode;
        logic [1:0] output_mode;
    } pe_cfg_t;

    localparam logic [3:0] PE_OP_ADD  = 4'h0;
    localparam logic [3:0] PE_OP_SUB  = 4'h1;
    localparam logic [3:0] PE_OP_MUL  = 4'h2;
    localparam logic [3:0] PE_OP_MULH = 4'h3;
    localparam logic [3:0] PE_OP_MACC = 4'h4;
    localparam logic [3:0] PE_OP_MIN  = 4'h5;
    localparam logic [3:0] PE_OP_MAX  = 4'h6;
    localparam logic [3:0] PE_OP_XOR  = 4'h7;
    localparam logic [3:0] PE_OP_OR   = 4'h8;
    localparam logic [3:0] PE_OP_AND  = 4'h9;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_DONE   = 2'd3
    } seq_state_e;

endpackage

// File: rtl/pe_sequencer.sv
// Streams one vector instruction element-by-element through an external PE: RF read, PE, write-back.
// Optional feature macro PE_SEQ_SCALAR_EN: latched scalar replaces the b operand when use_scalar is set.
module pe_sequencer
    import pe_pkg::*;
#(
    parameter int IDX_W = 5
)
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  pe_cfg_t              in_cfg,
    input  logic [4:0]           in_vs1,
    input  logic [4:0]           in_vs2,
    input  logic [4:0]           in_vd,
    input  logic [IDX_W:0]       in_vl,
    input  logic                 in_use_scalar,
    input  logic [31:0]          in_scalar,
    output logic [4+IDX_W:0]     rf_rd_addr_a,
    output logic [4+IDX_W:0]     rf_rd_addr_b,
    output logic [4+IDX_W:0]     rf_rd_addr_c,
    input  logic [31:0]          rf_rd_data_a,
    input  logic [31:0]          rf_rd_data_b,
    input  logic [31:0]          rf_rd_data_c,
    output logic [31:0]          pe_a,
    output logic [31:0]          pe_b,
    output logic [31:0]          pe_c,
    output pe_cfg_t              pe_cfg,
    input  logic [31:0]          pe_out,
    output logic                 wr_valid,
    input  logic                 wr_ready,
    output logic [4+IDX_W:0]     wr_addr,
    output logic [31:0]          wr_data,
    output logic                 busy,
    output logic                 done
);

    localparam logic [IDX_W:0] IDX_ONE = {{IDX_W{1'b0}}, 1'b1};

    seq_state_e       r_state;
    seq_state_e       w_state_nxt;
    pe_cfg_t          r_cfg;
    logic [4:0]       r_vs1;
    logic [4:0]       r_vs2;
    logic [4:0]       r_vd;
    logic [IDX_W:0]   r_vl;
    logic [IDX_W:0]   r_rd_idx;
    logic [IDX_W-1:0] r_data_idx;
    logic             r_data_last;
    logic             r_issued;
    logic             r_wr_valid;
    logic             r_wr_last;
    logic [4+IDX_W:0] r_wr_addr;
    logic [31:0]      r_wr_data;

    logic             w_accept;
    logic             w_stall;
    logic             w_issue;
    logic             w_last_issue;
    logic [IDX_W-1:0] w_addr_idx;

    assign w_accept     = in_valid && (r_state == ST_IDLE);
    assign w_stall      = r_wr_valid && !wr_ready;
    assign w_issue      = (r_state == ST_STREAM) && !w_stall;
    assign w_last_issue = (r_rd_idx == (r_vl - IDX_ONE));

    // While stalled, point the RF back at the element sitting in the data phase so the
    // one-cycle read latency keeps returning that same element until the write drains.
    assign w_addr_idx   = w_stall ? r_data_idx : r_rd_idx[IDX_W-1:0];
    assign rf_rd_addr_a = {r_vs2, w_addr_idx};
    assign rf_rd_addr_b = {r_vs1, w_addr_idx};
    assign rf_rd_addr_c = {r_vd,  w_addr_idx};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    w_state_nxt = (in_vl == '0) ? ST_DONE : ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (w_issue && w_last_issue) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (r_wr_valid && wr_ready && r_wr_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Three-stage pipe: address issue -> data phase (r_issued) -> registered write-back.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cfg       <= '0;
            r_vs1       <= '0;
            r_vs2       <= '0;
            r_vd        <= '0;
            r_vl        <= '0;
            r_rd_idx    <= '0;
            r_data_idx  <= '0;
            r_data_last <= 1'b0;
            r_issued    <= 1'b0;
            r_wr_valid  <= 1'b0;
            r_wr_last   <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
        end else begin
            if (w_accept) begin
                r_cfg    <= in_cfg;
                r_vs1    <= in_vs1;
                r_vs2    <= in_vs2;
                r_vd     <= in_vd;
                r_vl     <= in_vl;
                r_rd_idx <= '0;
            end
            if (!w_stall) begin
                r_issued   <= w_issue;
                r_wr_valid <= r_issued;
                if (w_issue) begin
                    r_rd_idx    <= r_rd_idx + IDX_ONE;
                    r_data_idx  <= r_rd_idx[IDX_W-1:0];
                    r_data_last <= w_last_issue;
                end
                if (r_issued) begin
                    r_wr_data <= pe_out;
                    r_wr_addr <= {r_vd, r_data_idx};
                    r_wr_last <= r_data_last;
                end
            end
        end
    end

    assign pe_a = r_issued ? rf_rd_data_a : '0;
    assign pe_c = r_issued ? rf_rd_data_c : '0;

`ifdef PE_SEQ_SCALAR_EN
    logic        r_use_scalar;
    logic [31:0] r_scalar;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_use_scalar <= 1'b0;
            r_scalar     <= '0;
        end else if (w_accept) begin
            r_use_scalar <= in_use_scalar;
            r_scalar     <= in_scalar;
        end
    end

    assign pe_b = r_use_scalar ? r_scalar : (r_issued ? rf_rd_data_b : '0);
`else
    logic w_unused_scalar;
    assign w_unused_scalar = ^{in_use_scalar, in_scalar};
    assign pe_b = r_issued ? rf_rd_data_b : '0;
`endif

    assign pe_cfg   = r_cfg;
    assign wr_valid = r_wr_valid;
    assign wr_addr  = r_wr_addr;
    assign wr_data  = r_wr_data;
    assign in_ready = (r_state == ST_IDLE);
    assign busy     = (r_state != ST_IDLE);
    assign done     = (r_state == ST_DONE);

endmodule

// File: tb/tb_pe_sequencer.sv
// Directed bench for pe_sequencer with a synchronous-read register file and a small ADD/MUL PE model.
module tb_pe_sequencer;
    import pe_pkg::*;

    localparam int IDX_W = 5;
    localparam int AW    = 5 + IDX_W;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    pe_cfg_t        in_cfg;
    logic [4:0]     in_vs1, in_vs2, in_vd;
    logic [IDX_W:0] in_vl;
    logic           in_use_scalar;
    logic [31:0]    in_scalar;
    logic [AW-1:0]  rf_rd_addr_a, rf_rd_addr_b, rf_rd_addr_c;
    logic [31:0]    rf_rd_data_a, rf_rd_data_b, rf_rd_data_c;
    logic [31:0]    pe_a, pe_b, pe_c;
    pe_cfg_t        pe_cfg;
    logic [31:0]    pe_out;
    logic           wr_valid, wr_ready;
    logic [AW-1:0]  wr_addr;
    logic [31:0]    wr_data;
    logic           busy, done;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int acc   = 0;

    logic [31:0] rf [0:(1<<AW)-1];

    logic          tr_valid [0:63];
    logic [AW-1:0] tr_addr  [0:63];
    logic [31:0]   tr_data  [0:63];
    logic          tr_ready [0:63];
    logic [31:0]   tr_pea   [0:63];
    int            wr_n, done_n, done_cyc;
    int            wr_cyc   [0:63];
    logic [AW-1:0] wr_a     [0:63];
    logic [31:0]   wr_d     [0:63];

    pe_sequencer #(.IDX_W(IDX_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_cfg(in_cfg),
        .in_vs1(in_vs1), .in_vs2(in_vs2), .in_vd(in_vd), .in_vl(in_vl),
        .in_use_scalar(in_use_scalar), .in_scalar(in_scalar),
        .rf_rd_addr_a(rf_rd_addr_a), .rf_rd_addr_b(rf_rd_addr_b), .rf_rd_addr_c(rf_rd_addr_c),
        .rf_rd_data_a(rf_rd_data_a), .rf_rd_data_b(rf_rd_data_b), .rf_rd_data_c(rf_rd_data_c),
        .pe_a(pe_a), .pe_b(pe_b), .pe_c(pe_c), .pe_cfg(pe_cfg), .pe_out(pe_out),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Register file: data valid one cycle after the address
    always @(posedge clk) begin
        rf_rd_data_a <= rf[rf_rd_addr_a];
        rf_rd_data_b <= rf[rf_rd_addr_b];
        rf_rd_data_c <= rf[rf_rd_addr_c];
    end

    always_comb begin
        case (pe_cfg.op)
            PE_OP_ADD: pe_out = pe_a + pe_b;
            PE_OP_MUL: pe_out = pe_a * pe_b;
            default:   pe_out = pe_a;
        endcase
    end

    task automatic set_elem(input int r, input int idx, input logic [31:0] val);
        rf[(r << IDX_W) + idx] = val;
    endtask

    task automatic issue(input pe_cfg_t cfg, input logic [4:0] vs1, input logic [4:0] vs2,
                         input logic [4:0] vd, input logic [IDX_W:0] vl,
                         input logic us, input logic [31:0] sc);
        in_cfg        = cfg;
        in_vs1        = vs1;
        in_vs2        = vs2;
        in_vd         = vd;
        in_vl         = vl;
        in_use_scalar = us;
        in_scalar     = sc;
        in_valid      = 1'b1;
        acc           = cyc;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic collect(input int ncyc, input int lo, input int hi);
        int off;
        wr_n     = 0;
        done_n   = 0;
        done_cyc = -1;
        for (int i = 0; i < ncyc; i++) begin
            off = cyc - acc;
            wr_ready = (off >= lo && off <= hi) ? 1'b0 : 1'b1;
            #1;
            if (off < 64) begin
                tr_valid[off] = wr_valid;
                tr_addr[off]  = wr_addr;
                tr_data[off]  = wr_data;
                tr_ready[off] = in_ready;
                tr_pea[off]   = pe_a;
            end
            if (wr_valid && wr_ready && wr_n < 64) begin
                wr_cyc[wr_n] = off;
                wr_a[wr_n]   = wr_addr;
                wr_d[wr_n]   = wr_data;
                wr_n++;
            end
            if (done) begin
                if (done_n == 0) done_cyc = off;
                done_n++;
            end
            @(negedge clk);
        end
        wr_ready = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (wr_valid !== 1'b0) begin bad++; $display("FAIL reset_wr_valid: got %b want 0", wr_valid); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (rf_rd_addr_a !== '0) begin bad++; $display("FAIL reset_rd_addr: got %h want 0", rf_rd_addr_a); end
        total++; if (wr_data !== '0 || wr_addr !== '0) begin bad++; $display("FAIL reset_wr_regs: got %h/%h want 0/0", wr_addr, wr_data); end
        total++; if (pe_cfg !== '0) begin bad++; $display("FAIL reset_cfg: got %h want 0", pe_cfg); end
        rst = 1'b0;
        @(negedge clk);
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_basic;
        pe_cfg_t cfg;
        logic [AW-1:0] ea;
        cfg = '0;
        cfg.op = PE_OP_ADD;
        cfg.vsew = 2'd2;
        cfg.mul_us = 2'd1;
        cfg.output_mode = 2'd3;
        for (int k = 0; k < 4; k++) begin
            set_elem(3, k, 32'(k + 1));
            set_elem(7, k, 32'(10 * (k + 1)));
        end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL basic_ready_before: got %b want 1", in_ready); end
        issue(cfg, 5'd7, 5'd3, 5'd12, 6'd4, 1'b0, 32'd0);
        total++; if (pe_cfg !== cfg) begin bad++; $display("FAIL basic_pe_cfg: got %h want %h", pe_cfg, cfg); end
        total++; if (busy !== 1'b1 || in_ready !== 1'b0) begin bad++; $display("FAIL basic_busy: got busy=%b ready=%b want 1/0", busy, in_ready); end
        collect(14, -1, -1);
        total++; if (tr_pea[2] !== 32'd1 || tr_pea[3] !== 32'd2) begin bad++; $display("FAIL basic_pe_a: got %0d,%0d want 1,2", tr_pea[2], tr_pea[3]); end
        total++; if (wr_n !== 4) begin bad++; $display("FAIL basic_wr_count: got %0d want 4", wr_n); end
        for (int k = 0; k < 4 && k < wr_n; k++) begin
            ea = {5'd12, k[IDX_W-1:0]};
            total++; if (wr_a[k] !== ea || wr_d[k] !== 32'(11 * (k + 1)) || wr_cyc[k] !== 3 + k) begin
                bad++; $display("FAIL basic_write%0d: got addr=%h data=%0d cyc=%0d want %h/%0d/%0d",
                                k, wr_a[k], wr_d[k], wr_cyc[k], ea, 11 * (k + 1), 3 + k);
            end
        end
        total++; if (done_cyc !== 7 || done_n !== 1) begin bad++; $display("FAIL basic_done: got cyc=%0d n=%0d want 7/1", done_cyc, done_n); end
    endtask

    task automatic test_stall;
        pe_cfg_t cfg;
        logic [AW-1:0] ea;
        cfg = '0;
        cfg.op = PE_OP_ADD;
        issue(cfg, 5'd7, 5'd3, 5'd12, 6'd4, 1'b0, 32'd0);
        collect(16, 4, 6);
        for (int o = 4; o <= 6; o++) begin
            total++; if (tr_valid[o] !== 1'b1 || tr_data[o] !== 32'd22 || tr_addr[o] !== {5'd12, 5'd1}) begin
                bad++; $display("FAIL stall_hold%0d: got v=%b addr=%h data=%0d want 1/%h/22",
                                o, tr_valid[o], tr_addr[o], tr_data[o], {5'd12, 5'd1});
            end
        end
        total++; if (wr_n !== 4) begin bad++; $display("FAIL stall_wr_count: got %0d want 4", wr_n); end
        for (int k = 0; k < 4 && k < wr_n; k++) begin
            ea = {5'd12, k[IDX_W-1:0]};
            total++; if (wr_a[k] !== ea || wr_d[k] !== 32'(11 * (k + 1)) || wr_cyc[k] !== ((k == 0) ? 3 : 6 + k)) begin
                bad++; $display("FAIL stall_write%0d: got addr=%h data=%0d cyc=%0d want %h/%0d/%0d",
                                k, wr_a[k], wr_d[k], wr_cyc[k], ea, 11 * (k + 1), (k == 0) ? 3 : 6 + k);
            end
        end
        total++; if (done_cyc !== 10 || done_n !== 1) begin bad++; $display("FAIL stall_done: got cyc=%0d n=%0d want 10/1", done_cyc, done_n); end
    endtask

    task automatic test_vl0;
        pe_cfg_t cfg;
        cfg = '0;
        issue(cfg, 5'd1, 5'd2, 5'd3, 6'd0, 1'b0, 32'd0);
        collect(6, -1, -1);
        total++; if (wr_n !== 0) begin bad++; $display("FAIL vl0_writes: got %0d want 0", wr_n); end
        total++; if (done_cyc !== 1 || done_n !== 1) begin bad++; $display("FAIL vl0_done: got cyc=%0d n=%0d want 1/1", done_cyc, done_n); end
        total++; if (tr_ready[1] !== 1'b0 || tr_ready[2] !== 1'b1) begin bad++; $display("FAIL vl0_ready: got %b,%b want 0,1", tr_ready[1], tr_ready[2]); end
    endtask

    task automatic test_abort;
        pe_cfg_t cfg;
        int nw, nd;
        cfg = '0;
        cfg.op = PE_OP_ADD;
        issue(cfg, 5'd7, 5'd3, 5'd12, 6'd8, 1'b0, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        total++; if (wr_valid !== 1'b0) begin bad++; $display("FAIL abort_wr_valid: got %b want 0", wr_valid); end
        @(negedge clk);
        rst = 1'b0;
        nw = 0;
        nd = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (wr_valid) nw++;
            if (done) nd++;
        end
        total++; if (nw !== 0 || nd !== 0) begin bad++; $display("FAIL abort_quiet: got writes=%0d dones=%0d want 0/0", nw, nd); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL abort_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_scalar;
        pe_cfg_t cfg;
        logic [31:0] e0, e1;
        cfg = '0;
        cfg.op = PE_OP_MUL;
        set_elem(4, 0, 32'd2);
        set_elem(4, 1, 32'd3);
        set_elem(5, 0, 32'd7);
        set_elem(5, 1, 32'd9);
`ifdef PE_SEQ_SCALAR_EN
        e0 = 32'd10;
        e1 = 32'd15;
`else
        e0 = 32'd14;
        e1 = 32'd27;
`endif
        issue(cfg, 5'd5, 5'd4, 5'd6, 6'd2, 1'b1, 32'd5);
        collect(10, -1, -1);
        total++; if (wr_n !== 2) begin bad++; $display("FAIL scalar_count: got %0d want 2", wr_n); end
        total++; if (wr_d[0] !== e0 || wr_d[1] !== e1) begin bad++; $display("FAIL scalar_data: got %0d,%0d want %0d,%0d", wr_d[0], wr_d[1], e0, e1); end
        total++; if (wr_a[1] !== {5'd6, 5'd1} || done_cyc !== 5) begin bad++; $display("FAIL scalar_tail: got addr=%h done=%0d want %h/5", wr_a[1], done_cyc, {5'd6, 5'd1}); end
    endtask

    task automatic test_back_to_back;
        pe_cfg_t cfg;
        int n_acc, nw, nd, off;
        int acc_off [0:3];
        int w_cyc   [0:7];
        logic [31:0] w_dat [0:7];
        logic [AW-1:0] w_adr [0:7];
        int d_cyc   [0:3];
        cfg = '0;
        cfg.op = PE_OP_ADD;
        in_cfg = cfg;
        in_vs1 = 5'd7;
        in_vs2 = 5'd3;
        in_vd  = 5'd9;
        in_vl  = 6'd2;
        in_use_scalar = 1'b0;
        in_scalar = '0;
        in_valid = 1'b1;
        acc = cyc;
        n_acc = 0;
        nw = 0;
        nd = 0;
        for (int i = 0; i < 16; i++) begin
            off = cyc - acc;
            if (n_acc == 2) in_valid = 1'b0;
            if (off == 1) begin
                in_cfg.op = PE_OP_MUL;
                in_vd = 5'd10;
                in_vl = 6'd1;
            end
            #1;
            if (in_valid && in_ready && n_acc < 4) begin acc_off[n_acc] = off; n_acc++; end
            if (wr_valid && wr_ready && nw < 8) begin w_cyc[nw] = off; w_dat[nw] = wr_data; w_adr[nw] = wr_addr; nw++; end
            if (done && nd < 4) begin d_cyc[nd] = off; nd++; end
            @(negedge clk);
        end
        in_valid = 1'b0;
        total++; if (n_acc !== 2 || acc_off[1] !== 6) begin bad++; $display("FAIL b2b_accept: got n=%0d second=%0d want 2/6", n_acc, acc_off[1]); end
        total++; if (nw !== 3) begin bad++; $display("FAIL b2b_wr_count: got %0d want 3", nw); end
        total++; if (nw > 2 && (w_dat[1] !== 32'd22 || w_adr[2] !== {5'd10, 5'd0} || w_dat[2] !== 32'd10 || w_cyc[2] !== 9)) begin
            bad++; $display("FAIL b2b_writes: got d1=%0d a2=%h d2=%0d c2=%0d want 22/%h/10/9", w_dat[1], w_adr[2], w_dat[2], w_cyc[2], {5'd10, 5'd0});
        end
        total++; if (nd !== 2 || d_cyc[0] !== 5 || d_cyc[1] !== 10) begin bad++; $display("FAIL b2b_done: got n=%0d c0=%0d c1=%0d want 2/5/10", nd, d_cyc[0], d_cyc[1]); end
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) rf[i] = '0;
        rst = 1'b1;
        in_valid = 1'b0;
        in_cfg = '0;
        in_vs1 = '0;
        in_vs2 = '0;
        in_vd = '0;
        in_vl = '0;
        in_use_scalar = 1'b0;
        in_scalar = '0;
        wr_ready = 1'b1;
        @(negedge clk);
        test_reset;
        test_basic;
        test_stall;
        test_vl0;
        test_abort;
        test_scalar;
        test_back_to_back;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
